// File: rtl/dispval_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispval_pkg
// Description : Shared types and helpers for the display validator: FSM state
//               encoding, default code width and counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package dispval_pkg;

    // Qualification state; 2-bit encoding shared with the multi-channel arbiter
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        VALID   = 2'd2,
        HOLD    = 2'd3
    } dispval_state_t;

    localparam int c_code_w_default = 3;

    // One counter serves both qualification and hold, so it is sized for the
    // larger terminal count; never narrower than one bit.
    function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
        int m;
        m = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dispval_code_match.sv
`default_nettype none
// ============================================================================
// Module      : dispval_code_match
// Description : Combinational code matcher. ok = code is displayable and the
//               interface is active; same = code equals the captured code.
//               Kept standalone for reuse by the multi-channel arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module dispval_code_match #(
    parameter int CODE_W = 3
) (
    input  logic [CODE_W-1:0]        code,
    input  logic [CODE_W-1:0]        cap,
    input  logic                     enable,
    input  logic [(1<<CODE_W)-1:0]   valid_mask,
    output logic                     ok,
    output logic                     same
);

    // A disabled interface never matches, whatever the code lines show
    assign ok   = enable & valid_mask[code];
    assign same = enable & (code == cap);

endmodule
`default_nettype wire

// File: rtl/display_validator_seq.sv
`default_nettype none
// ============================================================================
// Module      : display_validator_seq
// Description : Display qualification in front of the 7-segment decoder.
//               A displayable code must be stable for STABLE_CYCLES edges
//               before it is shown, and stays shown for HOLD_CYCLES edges
//               after it disappears. All outputs are registered.
//               Optional macro DISPVAL_EVENT_COUNT_EN adds valid_events[7:0],
//               a saturating count of fresh qualifications.
// Revision    : 1.0 - initial release
// ============================================================================
module display_validator_seq
    import dispval_pkg::*;
#(
    parameter int                       CODE_W        = c_code_w_default,
    parameter logic [(1<<CODE_W)-1:0]   VALID_MASK    = 8'b0000_0100,
    parameter int                       STABLE_CYCLES = 4,
    parameter int                       HOLD_CYCLES   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CODE_W-1:0]   code,
    output logic                validout,
    output logic [CODE_W-1:0]   disp_code,
    output logic                qualifying
`ifdef DISPVAL_EVENT_COUNT_EN
    ,
    output logic [7:0]          valid_events
`endif
);

    localparam int                 c_cnt_w       = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one         = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLD_CYCLES);

    dispval_state_t      r_state;
    dispval_state_t      w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [CODE_W-1:0]   r_cap;
    logic [CODE_W-1:0]   w_cap_nxt;
    logic                w_ok;
    logic                w_same;
    logic                r_validout;
    logic [CODE_W-1:0]   r_disp_code;
    logic                r_qualifying;
    logic                w_valid_nxt;

    dispval_code_match #(
        .CODE_W     (CODE_W)
    ) u_match (
        .code       (code),
        .cap        (r_cap),
        .enable     (enable),
        .valid_mask (VALID_MASK),
        .ok         (w_ok),
        .same       (w_same)
    );

    // Next-state, counter and capture decode; the counter restarts on every transition
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        unique case (r_state)
            IDLE: begin
                if (w_ok) begin
                    w_cap_nxt = code;
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = VALID;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = QUALIFY;
                        w_cnt_nxt   = c_one;
                    end
                end
            end
            QUALIFY: begin
                if (!w_ok) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (code != r_cap) begin
                    // a different displayable code starts its own run from scratch
                    w_cap_nxt = code;
                    w_cnt_nxt = c_one;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = VALID;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            VALID: begin
                // any non-match, including another displayable code, leaves VALID
                if (!w_same) begin
                    if (HOLD_CYCLES == 0) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = c_one;
                    end
                end
            end
            HOLD: begin
                if (w_same) begin
                    w_state_nxt = VALID;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_hold_last) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_cap_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_cap_nxt   = '0;
            end
        endcase
    end

    assign w_valid_nxt = (w_state_nxt == VALID) || (w_state_nxt == HOLD);

    // State registers plus output flops decoded from the next state and capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cap        <= '0;
            r_validout   <= 1'b0;
            r_disp_code  <= '0;
            r_qualifying <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cap        <= w_cap_nxt;
            r_validout   <= w_valid_nxt;
            r_disp_code  <= w_valid_nxt ? w_cap_nxt : '0;
            r_qualifying <= (w_state_nxt == QUALIFY);
        end
    end

    assign validout   = r_validout;
    assign disp_code  = r_disp_code;
    assign qualifying = r_qualifying;

`ifdef DISPVAL_EVENT_COUNT_EN
    logic       w_enter_valid;
    logic [7:0] r_valid_events;

    // Only fresh qualifications count; a HOLD->VALID return is the same display episode
    assign w_enter_valid = (w_state_nxt == VALID) && ((r_state == IDLE) || (r_state == QUALIFY));

    // Saturating qualification counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_events <= 8'd0;
        end else if (w_enter_valid && (r_valid_events != 8'hFF)) begin
            r_valid_events <= r_valid_events + 8'd1;
        end
    end

    assign valid_events = r_valid_events;
`endif

endmodule
`default_nettype wire

// File: tb/tb_display_validator_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_validator_seq
// Description : Self-checking bench for display_validator_seq. Three instances
//               (default, fast STABLE=1/HOLD=0, and a multi-code mask) share
//               one stimulus stream; a run-length behavioural model predicts
//               every output each cycle, and directed literals pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_validator_seq;

    localparam int         N_DUT    = 3;
    localparam int         STB [3]  = '{4, 1, 3};
    localparam int         HLD [3]  = '{8, 0, 2};
    localparam logic [7:0] MSK [3]  = '{8'h04, 8'h24, 8'h26};
    // {enable, code} directed pattern table
    localparam logic [3:0] PAT [16] = '{4'hA, 4'hA, 4'h9, 4'hA, 4'hA, 4'hA, 4'hA, 4'hD,
                                        4'hD, 4'h2, 4'hA, 4'hA, 4'hA, 4'hA, 4'h8, 4'hB};

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] code;

    logic       dv_valid [N_DUT];
    logic [2:0] dv_disp  [N_DUT];
    logic       dv_qual  [N_DUT];
`ifdef DISPVAL_EVENT_COUNT_EN
    logic [7:0] dv_ev    [N_DUT];
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    // Behavioural model state: displayed flag/code, run length of the current
    // candidate, consecutive misses while displayed, qualification count
    bit         m_shown  [N_DUT];
    logic [2:0] m_code   [N_DUT];
    int         m_streak [N_DUT];
    logic [2:0] m_scode  [N_DUT];
    int         m_miss   [N_DUT];
    int         m_ev     [N_DUT];

    display_validator_seq #(.CODE_W(3), .VALID_MASK(MSK[0]), .STABLE_CYCLES(STB[0]), .HOLD_CYCLES(HLD[0])) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .code(code),
        .validout(dv_valid[0]), .disp_code(dv_disp[0]), .qualifying(dv_qual[0])
`ifdef DISPVAL_EVENT_COUNT_EN
        , .valid_events(dv_ev[0])
`endif
    );

    display_validator_seq #(.CODE_W(3), .VALID_MASK(MSK[1]), .STABLE_CYCLES(STB[1]), .HOLD_CYCLES(HLD[1])) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .code(code),
        .validout(dv_valid[1]), .disp_code(dv_disp[1]), .qualifying(dv_qual[1])
`ifdef DISPVAL_EVENT_COUNT_EN
        , .valid_events(dv_ev[1])
`endif
    );

    display_validator_seq #(.CODE_W(3), .VALID_MASK(MSK[2]), .STABLE_CYCLES(STB[2]), .HOLD_CYCLES(HLD[2])) u_dut_c (
        .clk(clk), .reset(reset), .enable(enable), .code(code),
        .validout(dv_valid[2]), .disp_code(dv_disp[2]), .qualifying(dv_qual[2])
`ifdef DISPVAL_EVENT_COUNT_EN
        , .valid_events(dv_ev[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s[dut%0d] got %0d expected %0d at %0t", name, k, act, exp, $time);
    endtask

    task automatic tick(input logic r, input logic e, input logic [2:0] c);
        reset  = r;
        enable = e;
        code   = c;
        @(posedge clk);
        #3;
    endtask

    // Model: a code is shown once it has been seen displayable STB times in a
    // row, and stays shown until it has been missing for more than HLD edges
    always @(posedge clk) begin
        for (int k = 0; k < N_DUT; k++) begin
            logic [7:0] msk;
            msk = MSK[k];
            if (reset) begin
                m_shown[k] = 1'b0; m_code[k] = '0; m_streak[k] = 0;
                m_scode[k] = '0;   m_miss[k] = 0;  m_ev[k]     = 0;
            end else if (m_shown[k]) begin
                if (enable && (code == m_code[k])) begin
                    m_miss[k] = 0;
                end else begin
                    m_miss[k] = m_miss[k] + 1;
                    if (m_miss[k] > HLD[k]) begin
                        m_shown[k] = 1'b0;
                        m_code[k]  = '0;
                    end
                end
            end else if (enable && msk[code]) begin
                if ((m_streak[k] > 0) && (code == m_scode[k])) begin
                    m_streak[k] = m_streak[k] + 1;
                end else begin
                    m_streak[k] = 1;
                    m_scode[k]  = code;
                end
                if (m_streak[k] >= STB[k]) begin
                    m_shown[k]  = 1'b1;
                    m_code[k]   = code;
                    m_miss[k]   = 0;
                    m_streak[k] = 0;
                    if (m_ev[k] < 255) m_ev[k] = m_ev[k] + 1;
                end
            end else begin
                m_streak[k] = 0;
            end
        end
    end

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < N_DUT; k++) begin
                chk("model_valid", k, int'(dv_valid[k]), int'(m_shown[k]));
                chk("model_disp",  k, int'(dv_disp[k]),  m_shown[k] ? int'(m_code[k]) : 0);
                chk("model_qual",  k, int'(dv_qual[k]),  (!m_shown[k] && (m_streak[k] > 0)) ? 1 : 0);
`ifdef DISPVAL_EVENT_COUNT_EN
                chk("model_events", k, int'(dv_ev[k]), m_ev[k]);
`endif
            end
        end
    end

    initial begin
        logic [3:0] p;
        reset = 1'b1; enable = 1'b0; code = 3'd0;
        tick(1, 0, 0);
        cmp_on = 1'b1;
        tick(1, 0, 0);
        chk("rst_valid", 0, int'(dv_valid[0]), 0);
        chk("rst_disp",  0, int'(dv_disp[0]),  0);
        chk("rst_qual",  0, int'(dv_qual[0]),  0);

        // Stable code 2: three qualifying edges, shown after the fourth
        tick(0, 1, 2);
        chk("t1_qual", 0, int'(dv_qual[0]), 1);
        chk("t1_valid", 0, int'(dv_valid[0]), 0);
        chk("fast_valid", 1, int'(dv_valid[1]), 1);
        chk("fast_disp", 1, int'(dv_disp[1]), 2);
        for (int i = 2; i <= 3; i++) begin
            tick(0, 1, 2);
            chk("t1_qual", 0, int'(dv_qual[0]), 1);
            chk("t1_valid", 0, int'(dv_valid[0]), 0);
        end
        tick(0, 1, 2);
        chk("t1_valid4", 0, int'(dv_valid[0]), 1);
        chk("t1_disp4",  0, int'(dv_disp[0]),  2);
        chk("t1_qual4",  0, int'(dv_qual[0]),  0);

        // Short loss then return: no requalification, display never drops
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0);
            chk("hold_short_valid", 0, int'(dv_valid[0]), 1);
            chk("hold_short_disp",  0, int'(dv_disp[0]),  2);
        end
        tick(0, 1, 2);
        chk("hold_return_valid", 0, int'(dv_valid[0]), 1);
        chk("hold_return_qual",  0, int'(dv_qual[0]),  0);
        tick(0, 1, 2);

        // Full hold: eight edges still shown, blank after the ninth
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0);
            chk("hold_valid", 0, int'(dv_valid[0]), 1);
            chk("hold_disp",  0, int'(dv_disp[0]),  2);
        end
        tick(0, 1, 0);
        chk("hold_end_valid", 0, int'(dv_valid[0]), 0);
        chk("hold_end_disp",  0, int'(dv_disp[0]),  0);
        chk("fast_blank", 1, int'(dv_valid[1]), 0);

        // Interrupted qualification restarts from one
        for (int i = 0; i < 3; i++) tick(0, 1, 2);
        chk("fast_shown2", 1, int'(dv_valid[1]), 1);
        tick(0, 1, 5);
        chk("intr_qual",  0, int'(dv_qual[0]),  0);
        chk("intr_valid", 0, int'(dv_valid[0]), 0);
        chk("fast_no_switch_valid", 1, int'(dv_valid[1]), 0);
        chk("fast_no_switch_disp",  1, int'(dv_disp[1]),  0);
        tick(0, 1, 2);
        chk("restart_qual", 0, int'(dv_qual[0]), 1);
        tick(0, 1, 2);
        tick(0, 1, 2);
        chk("restart_valid3", 0, int'(dv_valid[0]), 0);
        tick(0, 1, 2);
        chk("restart_valid4", 0, int'(dv_valid[0]), 1);

        // Reset while in HOLD, then while in QUALIFY
        tick(0, 1, 0);
        tick(0, 1, 0);
        tick(1, 1, 2);
        chk("rst_hold_valid", 0, int'(dv_valid[0]), 0);
        chk("rst_hold_disp",  0, int'(dv_disp[0]),  0);
        chk("rst_hold_qual",  0, int'(dv_qual[0]),  0);
        tick(0, 1, 2);
        tick(0, 1, 2);
        chk("pre_rst_qual", 0, int'(dv_qual[0]), 1);
        tick(1, 1, 2);
        chk("rst_qual_qual",  0, int'(dv_qual[0]),  0);
        chk("rst_qual_valid", 0, int'(dv_valid[0]), 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 2);

        // Dropping enable is a non-match even with a displayable code
        tick(0, 0, 2);
        chk("en_low_hold", 0, int'(dv_valid[0]), 1);
        chk("fast_en_low", 1, int'(dv_valid[1]), 0);
        tick(0, 1, 2);

        // Mixed directed pattern, checked by the model every cycle
        for (int i = 0; i < 48; i++) begin
            p = PAT[i % 16];
            tick(0, p[3], p[2:0]);
        end

`ifdef DISPVAL_EVENT_COUNT_EN
        tick(1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 2);
        chk("ev_first", 0, int'(dv_ev[0]), 1);
        for (int i = 0; i < 3; i++) tick(0, 1, 0);
        tick(0, 1, 2);
        chk("ev_hold_return", 0, int'(dv_ev[0]), 1);
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) tick(0, 1, 2);
            for (int i = 0; i < 9; i++) tick(0, 1, 0);
        end
        chk("ev_saturate", 0, int'(dv_ev[0]), 255);
`endif

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
